// File: rtl/uart_receiver.sv
// uart_receiver
//   Deserialises an asynchronous serial line into parallel words. Each frame has
//   one start bit, WORD_SIZE data bits sent MSB first, and one stop bit.
//   The block has no FIFO. The host must take data_recv on the cycle rx_valid_o pulses.
//
//   Ports:
//     clk          in   1          clock, rising edge
//     rst          in   1          synchronous active-high reset
//     rx           in   1          asynchronous serial line, idle high
//     data_recv    out  WORD_SIZE  last good word; held until the next good frame
//     rx_valid_o   out  1          1-cycle pulse when data_recv is updated
//     rx_frame_err out  1          1-cycle pulse when the stop bit is sampled low
//     rx_busy_o    out  1          high while the FSM is not in IDLE
//
//   Build option: define UART_RX_MAJORITY_EN to take a 2-of-3 vote of rx_s around
//   each sample point. The decision then comes one clock later than the nominal point.
module uart_receiver #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned CLOCK_FREQ = 1_000_000,
    parameter int unsigned BAUD_RATE  = 100_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [WORD_SIZE-1:0] data_recv,
    output logic                 rx_valid_o,
    output logic                 rx_frame_err,
    output logic                 rx_busy_o
);

    localparam int unsigned BIT_CLKS = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned HALF     = BIT_CLKS / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned VOTE_DLY = 1;
`else
    localparam int unsigned VOTE_DLY = 0;
`endif
    localparam logic [15:0] START_PT = 16'(HALF - 1 + VOTE_DLY);
    localparam logic [15:0] BIT_PT   = 16'(BIT_CLKS - 1);
    localparam int unsigned IDX_W    = $clog2(WORD_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state, state_n;
    logic [15:0]          cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [WORD_SIZE-1:0] shift, shift_n;
    logic [WORD_SIZE-1:0] data_n;
    logic                 valid_n, err_n;
    logic                 rx_m, rx_s;
    logic                 sample;

`ifdef UART_RX_MAJORITY_EN
    // rx_d1 and rx_d2 hold the two previous rx_s values.
    // The vote at count P therefore covers counts P-2, P-1 and P.
    // The start decision is placed one clock late (START_PT).
    // The data and stop decisions keep the BIT_CLKS spacing, so the whole sample grid moves +1 clock.
    logic rx_d1, rx_d2;
    assign sample = (rx_d2 & rx_d1) | (rx_d2 & rx_s) | (rx_d1 & rx_s);
`else
    assign sample = rx_s;
`endif

    assign rx_busy_o = (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = (state == IDLE) ? '0 : cnt + 16'd1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        data_n    = data_recv;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == START_PT) begin
                    cnt_n = '0;
                    if (!sample) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_PT) begin
                    cnt_n   = '0;
                    shift_n = {shift[WORD_SIZE-2:0], sample};
                    if (bit_idx == LAST_IDX) begin
                        state_n   = STOP;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_PT) begin
                    cnt_n = '0;
                    if (sample) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state_n != state) cnt_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            data_recv    <= '0;
            rx_valid_o   <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_m         <= 1'b1;
            rx_s         <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            rx_d1        <= 1'b1;
            rx_d2        <= 1'b1;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            shift        <= shift_n;
            data_recv    <= data_n;
            rx_valid_o   <= valid_n;
            rx_frame_err <= err_n;
            rx_m         <= rx;
            rx_s         <= rx_m;
`ifdef UART_RX_MAJORITY_EN
            rx_d1        <= rx_s;
            rx_d2        <= rx_d1;
`endif
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Directed bench for uart_receiver with WORD_SIZE=8 and BIT_CLKS=10.
//   Each expected strobe (good word, or frame error with the held data value) is
//   queued before its frame is driven. The queue is checked whenever a strobe appears.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_recv;
    logic       rx_valid_o;
    logic       rx_frame_err;
    logic       rx_busy_o;

    always #5 clk = ~clk;

    uart_receiver #(
        .WORD_SIZE (8),
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_recv   (data_recv),
        .rx_valid_o  (rx_valid_o),
        .rx_frame_err(rx_frame_err),
        .rx_busy_o   (rx_busy_o)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Outputs are sampled on the falling edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rx_valid_o === 1'b1 || rx_frame_err === 1'b1) begin
            chk("strobe_excl", 32'(rx_valid_o & rx_frame_err), 32'd0);
            chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("strobe_is_err", 32'(rx_frame_err), 32'(e.is_err));
                chk("strobe_data", 32'(data_recv), 32'(e.data));
            end
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // spike: 1-based clock index within the frame at which rx is forced low for one clock (0 = none)
    task automatic send_frame(input logic [7:0] d, input logic stop, input int spike);
        logic [9:0] bits;
        bits = {1'b0, d, stop};
        for (int b = 0; b < 10; b++) begin
            for (int t = 0; t < 10; t++) begin
                rx = (b * 10 + t + 1 == spike) ? 1'b0 : bits[9-b];
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        exp_data = 8'h00;
        repeat (3) tick();
        chk("reset_data", 32'(data_recv), 32'h0);
        chk("reset_valid", 32'(rx_valid_o), 32'h0);
        chk("reset_err", 32'(rx_frame_err), 32'h0);
        chk("reset_busy", 32'(rx_busy_o), 32'h0);
        rst = 1'b0;
        idle(5);

        // 1: single good frame
        sb.push_back('{1'b0, 8'hA5});
        exp_data = 8'hA5;
        send_frame(8'hA5, 1'b1, 0);
        idle(5);
        chk("t1_drained", 32'(sb.size()), 32'd0);
        chk("t1_data", 32'(data_recv), 32'(exp_data));
        chk("t1_busy", 32'(rx_busy_o), 32'd0);

        // 2: back-to-back frames, one stop bit each
        sb.push_back('{1'b0, 8'h3C});
        sb.push_back('{1'b0, 8'hC3});
        exp_data = 8'hC3;
        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'hC3, 1'b1, 0);
        idle(5);
        chk("t2_drained", 32'(sb.size()), 32'd0);
        chk("t2_data", 32'(data_recv), 32'(exp_data));

        // 3: 3-clock low glitch
        rx = 1'b0;
        repeat (3) tick();
        chk("t3_busy_in_start", 32'(rx_busy_o), 32'd1);
        idle(20);
        chk("t3_busy_after", 32'(rx_busy_o), 32'd0);
        chk("t3_data_held", 32'(data_recv), 32'(exp_data));

        // 4: stop bit low, line held low 30 clocks in total
        sb.push_back('{1'b1, exp_data});
        send_frame(8'h5A, 1'b0, 0);
        rx = 1'b0;
        repeat (20) tick();
        chk("t4_err_seen", 32'(sb.size()), 32'd0);
        chk("t4_busy_break", 32'(rx_busy_o), 32'd1);
        chk("t4_data_held", 32'(data_recv), 32'(exp_data));
        idle(5);
        chk("t4_busy_released", 32'(rx_busy_o), 32'd0);
        sb.push_back('{1'b0, 8'h81});
        exp_data = 8'h81;
        send_frame(8'h81, 1'b1, 0);
        idle(5);
        chk("t4_drained", 32'(sb.size()), 32'd0);
        chk("t4_data_next", 32'(data_recv), 32'(exp_data));

        // 5: reset in the middle of the data bits of 0xFF
        rx = 1'b0;
        repeat (10) tick();
        rx = 1'b1;
        repeat (30) tick();
        chk("t5_busy_mid", 32'(rx_busy_o), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_rst_data", 32'(data_recv), 32'h0);
        chk("t5_rst_valid", 32'(rx_valid_o), 32'h0);
        chk("t5_rst_err", 32'(rx_frame_err), 32'h0);
        chk("t5_rst_busy", 32'(rx_busy_o), 32'h0);
        rst = 1'b0;
        exp_data = 8'h00;
        idle(5);
        sb.push_back('{1'b0, 8'h12});
        exp_data = 8'h12;
        send_frame(8'h12, 1'b1, 0);
        idle(5);
        chk("t5_drained", 32'(sb.size()), 32'd0);
        chk("t5_data", 32'(data_recv), 32'(exp_data));

`ifdef UART_RX_MAJORITY_EN
        // 6: 1-clock low spike at the centre of data bit 3 (frame clock 46)
        sb.push_back('{1'b0, 8'hFF});
        exp_data = 8'hFF;
        send_frame(8'hFF, 1'b1, 46);
        idle(5);
        chk("t6_drained", 32'(sb.size()), 32'd0);
        chk("t6_data", 32'(data_recv), 32'(exp_data));
`endif

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
